// File: rtl/mem_pkg.sv
// Shared types for the mem_responder slice: FSM state encoding, data width,
// and the captured-request / registered-response records.
package mem_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    // The backing-memory request is live exactly while waiting in a memory state.
    function automatic logic is_mem_state(input state_e s);
        return (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and backing-memory signal bundle for mem_responder.
// slave is the responder's view, master is the view of the CPU plus memory.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_resp_cache_array.sv
// Direct-mapped one-word-per-line storage: valid bits, tags, data and the
// hit compare. A single write port both fills lines and updates store hits.
module mem_resp_cache_array
    import mem_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS;

    logic [DATA_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q, valid_d;

    logic [INDEX_BITS-1:0] lookup_idx, wr_idx;
    logic [TAG_W-1:0]      lookup_tag, wr_tag;

    assign lookup_idx = lookup_addr[INDEX_BITS-1:0];
    assign lookup_tag = lookup_addr[ADDR_W-1:INDEX_BITS];
    assign wr_idx     = wr_addr[INDEX_BITS-1:0];
    assign wr_tag     = wr_addr[ADDR_W-1:INDEX_BITS];

    assign hit      = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign hit_data = data_mem[lookup_idx];

    always_comb begin
        // NOTE: default first so every path assigns valid_d and no latch is inferred.
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_data;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding CPU memory responder with write-through, no-write-allocate
// cache; the cache is built only when MEM_RESPONDER_CACHE_EN is defined.
module mem_responder
    import mem_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    resp_t             resp_q, resp_d;

    logic              hit;
    logic [DATA_W-1:0] hit_data;

`ifdef MEM_RESPONDER_CACHE_EN
    logic [ADDR_W-1:0] lookup_addr;
    logic              cache_we;
    logic [DATA_W-1:0] cache_wdata;

    // Look up the incoming address when idle, the captured one while a store is in flight.
    assign lookup_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign cache_we    = bus.mem_ack &&
                         ((state_q == MEM_RD) || ((state_q == MEM_WR) && hit));
    assign cache_wdata = (state_q == MEM_RD) ? bus.mem_rdata : req_q.wdata;

    mem_resp_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .ADDR_W     (ADDR_W)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (lookup_addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .wr_en       (cache_we),
        .wr_addr     (addr_q),
        .wr_data     (cache_wdata)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        resp_d       = resp_q;
        resp_d.valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.write = bus.req_write;
                    req_d.wdata = bus.req_wdata;
                    addr_d      = bus.req_addr;
                    if (bus.req_write) begin
                        state_d = MEM_WR;
                    end else if (hit) begin
                        state_d      = RESP;
                        resp_d.valid = 1'b1;
                        resp_d.rdata = hit_data;
                    end else begin
                        state_d = MEM_RD;
                    end
                end
            end
            MEM_RD: begin
                if (bus.mem_ack) begin
                    state_d      = RESP;
                    resp_d.valid = 1'b1;
                    resp_d.rdata = bus.mem_rdata;
                end
            end
            MEM_WR: begin
                if (bus.mem_ack) begin
                    state_d      = RESP;
                    resp_d.valid = 1'b1;
                    resp_d.rdata = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_q.valid;
    assign bus.resp_rdata = resp_q.rdata;
    assign bus.mem_req    = is_mem_state(state_q);
    assign bus.mem_we     = (state_q == MEM_WR);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = req_q.wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; expectations follow MEM_RESPONDER_CACHE_EN
// (hits answer in one cycle with the cache, every load goes to memory without).
module tb_mem_responder;

`ifdef MEM_RESPONDER_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_responder_if #(.ADDR_W(16)) bus ();

    mem_responder #(
        .INDEX_BITS (8),
        .ADDR_W     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request from acceptance to response; a memory phase is acked after
    // ack_wait cycles of mem_req with ack_data, whatever the build.
    task automatic xact(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int ack_wait,
                        input logic [15:0] ack_data, input bit cached,
                        input logic [15:0] exp_rdata);
        bit          exp_mem;
        int          req_cycles;
        int          lat;
        bit          mem_ok;
        logic [15:0] rdata;
        exp_mem    = !(cached && CACHE_ON);
        req_cycles = 0;
        lat        = -1;
        mem_ok     = 1'b1;
        rdata      = 16'hxxxx;

        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = ~addr;
        bus.req_wdata = 16'h9999;

        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_cycles++;
                if (bus.mem_we !== wr || bus.mem_addr !== addr || (wr && bus.mem_wdata !== wdata))
                    mem_ok = 1'b0;
            end
            if (bus.resp_valid) begin
                lat   = k;
                rdata = bus.resp_rdata;
            end
            bus.mem_ack   = bus.mem_req && (req_cycles == ack_wait);
            bus.mem_rdata = ack_data;
        end
        bus.mem_ack = 1'b0;

        check({tag, ".latency"},  32'(lat),        exp_mem ? 32'(ack_wait + 1) : 32'd1);
        check({tag, ".memcycles"}, 32'(req_cycles), exp_mem ? 32'(ack_wait) : 32'd0);
        check({tag, ".memfields"}, 32'(mem_ok),     32'd1);
        check({tag, ".rdata"},    32'(rdata),      32'(exp_rdata));
        @(negedge clk);
        check({tag, ".pulse"},    32'(bus.resp_valid), 32'd0);
        check({tag, ".idle"},     32'(bus.req_ready),  32'd1);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        #12;
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_rdata", 32'(bus.resp_rdata), 32'd0);
        check("rst.mem_req",    32'(bus.mem_req),    32'd0);
        check("rst.mem_we",     32'(bus.mem_we),     32'd0);
        check("rst.mem_addr",   32'(bus.mem_addr),   32'd0);
        check("rst.mem_wdata",  32'(bus.mem_wdata),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.req_ready",  32'(bus.req_ready),  32'd1);

        // Stray ack while idle produces nothing.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1111;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("idle_ack.resp_valid", 32'(bus.resp_valid), 32'd0);

        xact("ld_cold",    1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, 16'hBEEF);
        xact("ld_hit",     1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b1, 16'hBEEF);
        xact("st_hit",     1'b1, 16'h0010, 16'h1234, 2, 16'h0BAD, 1'b0, 16'h0000);
        xact("ld_updated", 1'b0, 16'h0010, 16'h0000, 1, 16'h1234, 1'b1, 16'h1234);
        xact("ld_alias",   1'b0, 16'h0110, 16'h0000, 1, 16'hCAFE, 1'b0, 16'hCAFE);
        xact("ld_evicted", 1'b0, 16'h0010, 16'h0000, 1, 16'h1234, 1'b0, 16'h1234);
        xact("st_miss",    1'b1, 16'h0020, 16'h5555, 1, 16'h0BAD, 1'b0, 16'h0000);
        xact("ld_nofill",  1'b0, 16'h0020, 16'h0000, 2, 16'h5555, 1'b0, 16'h5555);
        xact("ld_ffff",    1'b0, 16'hFFFF, 16'h0000, 1, 16'hA5A5, 1'b0, 16'hA5A5);
        xact("ld_ffff2",   1'b0, 16'hFFFF, 16'h0000, 2, 16'hA5A5, 1'b1, 16'hA5A5);

        // Reset in the middle of a memory read, then a late ack.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0030;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst.pre_mem_req", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst.mem_req",    32'(bus.mem_req),    32'd0);
        check("mid_rst.mem_addr",   32'(bus.mem_addr),   32'd0);
        check("mid_rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.resp_valid || bus.mem_req) seen++;
        end
        check("mid_rst.late_ack", 32'(seen), 32'd0);
        check("mid_rst.ready",    32'(bus.req_ready), 32'd1);
        xact("ld_after_rst", 1'b0, 16'h0030, 16'h0000, 1, 16'h0BAD, 1'b0, 16'h0BAD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 8, cache index width (2^INDEX_BITS one-word lines).
REQ-002 SHALL have parameter ADDR_W, default 16, word address width; data width fixed at 16.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  CPU access request.
REQ-006 SHALL have port req_write  in  1  1=store, 0=load.
REQ-007 SHALL have port req_addr  in  ADDR_W  word address.
REQ-008 SHALL have port req_wdata  in  16  store data.
REQ-009 SHALL have port req_ready  out  1  request accepted when req_valid&&req_ready.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  16  load data, valid with resp_valid; 0 for stores.
REQ-012 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 16: backing-memory request.
REQ-013 SHALL have ports mem_ack in 1, mem_rdata in 16: backing-memory one-cycle completion, rdata valid with ack.

Function
REQ-014 SHALL implement FSM states IDLE, MEM_RD, MEM_WR, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE on accepted load hitting a valid line with matching tag, go to RESP; resp_valid asserted the following cycle (latency 1) with the cached word.
REQ-016 SHALL, on accepted load miss, go to MEM_RD, asserting mem_req=1, mem_we=0, mem_addr=captured address.
REQ-017 SHALL, in MEM_RD on mem_ack, write mem_rdata into the line, set valid, store tag, go to RESP returning mem_rdata.
REQ-018 SHALL, on accepted store, go to MEM_WR (write-through, no write-allocate): mem_req=1, mem_we=1, mem_addr/mem_wdata=captured values.
REQ-019 SHALL, in MEM_WR on mem_ack, update the line data if tag hit and valid (miss leaves cache unchanged), go to RESP with resp_rdata=0.
REQ-020 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable from entry into MEM_RD/MEM_WR until the mem_ack cycle; mem_req deasserts the cycle after ack.
REQ-021 SHALL register the request fields at acceptance; req_* changes while busy have no effect.
REQ-022 SHALL return from RESP to IDLE unconditionally after one cycle; a back-to-back request is accepted no earlier than the cycle after resp_valid.
REQ-023 SHALL ignore mem_ack in IDLE and RESP.
REQ-024 SHALL split address as index=addr[INDEX_BITS-1:0], tag=addr[ADDR_W-1:INDEX_BITS]; aliasing addresses evict each other; address 0xFFFF handled as any other.

Reset
REQ-025 SHALL, on reset assertion, immediately force state=IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all valid bits=0.
REQ-026 SHALL abandon any in-flight memory access on reset mid-operation; a late mem_ack after release is ignored, and no line is filled.
REQ-027 SHALL NOT reset cache data/tag arrays.

Configuration
REQ-028 SHALL honour macro MEM_RESPONDER_CACHE_EN: defined -> cache per REQ-015..019; undefined -> no cache arrays, every load goes IDLE->MEM_RD->RESP, stores unchanged.

Structure
REQ-029 SHALL place state encoding enum, data width constant, and request/response struct typedefs in shared package mem_pkg.
REQ-030 SHALL isolate tag/valid/data storage and hit compare in sub-module mem_resp_cache_array, instantiated only when MEM_RESPONDER_CACHE_EN is defined.

Verification
REQ-031 Load 0x0010 cold, mem_ack 3 cycles later with 0xBEEF -> one mem_req read of 0x0010, resp_rdata=0xBEEF; repeat load -> resp in 1 cycle, no mem_req.
REQ-032 Store 0x0010<=0x1234 after fill, then load 0x0010 -> mem write 0x1234, load hits returning 0x1234 without mem_req.
REQ-033 Load 0x0110 after 0x0010 cached (INDEX_BITS=8) -> miss, refill evicts; next load 0x0010 misses again.
REQ-034 Store to uncached 0x0020, then load 0x0020 -> store causes no fill; load misses.
REQ-035 Assert reset during MEM_RD, then mem_ack after release -> mem_req=0 immediately, ack ignored, no resp_valid, subsequent load of same address misses.
REQ-036 Build without MEM_RESPONDER_CACHE_EN, load 0x0010 twice -> two memory reads, both responses correct.
